// File: rtl/adct_chan_timer.sv
// One ADCT channel: sample-rate prescaler, pulse-event prescaler and a delay/width pulse shaper.
// All outputs are registered; the pulse path is forced idle whenever either enable is low.
module adct_chan_timer #(
  parameter int SRATE_PSC_W = 8,
  parameter int PULS_PSC_W  = 23,
  parameter int DLY_W       = 9,
  parameter int PWIDTH_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_srate_en,
  input  logic                   i_puls_en,
  input  logic [SRATE_PSC_W-1:0] i_srate_psc_div,
  input  logic [PULS_PSC_W-1:0]  i_puls_psc_div,
  input  logic [DLY_W-1:0]       i_puls_dly,
  input  logic [PWIDTH_W-1:0]    i_puls_pwidth,
  input  logic                   i_ovr_clr,
  output logic                   o_srate_stb,
  output logic                   o_puls_stb,
  output logic                   o_puls,
  output logic                   o_puls_busy,
  output logic                   o_puls_ovr
);

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;

  state_t                 state;
  logic                   started;
  logic [SRATE_PSC_W-1:0] srate_cnt;
  logic [SRATE_PSC_W-1:0] srate_cur;
  logic [PULS_PSC_W-1:0]  puls_cnt;
  logic [PULS_PSC_W-1:0]  puls_cur;
  logic [DLY_W-1:0]       dly_cnt;
  logic [PWIDTH_W-1:0]    width_cnt;
  logic                   srate_tick;
  logic                   puls_on;
  logic                   puls_tick;

  // The first edge out of reset sees the divisors directly, exactly like a fresh enable.
  always_comb begin
    srate_cur  = started ? srate_cnt : i_srate_psc_div;
    puls_cur   = started ? puls_cnt : i_puls_psc_div;
    srate_tick = i_srate_en && (srate_cur == '0);
    puls_on    = i_srate_en && i_puls_en;
    puls_tick  = puls_on && srate_tick && (puls_cur == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      started     <= 1'b0;
      srate_cnt   <= '0;
      puls_cnt    <= '0;
      o_srate_stb <= 1'b0;
      o_puls_stb  <= 1'b0;
    end else begin
      started     <= 1'b1;
      o_srate_stb <= srate_tick;
      o_puls_stb  <= puls_tick;
      if (!i_srate_en || srate_tick)
        srate_cnt <= i_srate_psc_div;
      else
        srate_cnt <= srate_cur - SRATE_PSC_W'(1);
      if (!puls_on || puls_tick)
        puls_cnt <= i_puls_psc_div;
      else if (srate_tick)
        puls_cnt <= puls_cur - PULS_PSC_W'(1);
      else
        puls_cnt <= puls_cur;
    end
  end

  // Pulse shaper: the registered o_puls_stb is the event, so o_puls rises dly+1 cycles after it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      width_cnt   <= '0;
      o_puls      <= 1'b0;
      o_puls_busy <= 1'b0;
      o_puls_ovr  <= 1'b0;
    end else begin
      if (o_puls_stb && state != IDLE)
        o_puls_ovr <= 1'b1;
      else if (i_ovr_clr)
        o_puls_ovr <= 1'b0;

      if (!puls_on) begin
        state       <= IDLE;
        o_puls      <= 1'b0;
        o_puls_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (o_puls_stb && i_puls_pwidth != '0) begin
              width_cnt   <= i_puls_pwidth - PWIDTH_W'(1);
              o_puls_busy <= 1'b1;
              if (i_puls_dly == '0) begin
                state  <= ACTIVE;
                o_puls <= 1'b1;
              end else begin
                state   <= DELAY;
                dly_cnt <= i_puls_dly - DLY_W'(1);
              end
            end
          end
          DELAY: begin
            if (dly_cnt == '0) begin
              state  <= ACTIVE;
              o_puls <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - DLY_W'(1);
            end
          end
          ACTIVE: begin
            if (width_cnt == '0) begin
              state       <= IDLE;
              o_puls      <= 1'b0;
              o_puls_busy <= 1'b0;
            end else begin
              width_cnt <= width_cnt - PWIDTH_W'(1);
            end
          end
          default: begin
            state       <= IDLE;
            o_puls      <= 1'b0;
            o_puls_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
